wshb_sram_slave: RTL and testbench
==================================

WSHB_SRAM_SLAVE -- requirements
Module: wshb_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of internal memory (power of two, 16..65536).
REQ-002 SHALL have parameter BURST_EN, default 1, meaning linear-burst support (0 = every cycle treated as classic).
REQ-003 sys_clk  in  1  the single clock; every event is on its rising edge.
REQ-004 sys_rst_n  in  1  the reset, synchronous and active-low.
REQ-005 adr  in  32  byte address; word index = adr[AW+1:2], where AW = log2(DEPTH_WORDS).
REQ-006 dat_ms  in  32  write data from the master.
REQ-007 dat_sm  out  32  read data to the master.
REQ-008 sel  in  4  byte enables; sel[i] selects dat_ms[8i+7:8i].
REQ-009 we / stb / cyc  in  1 each  write enable, strobe and bus cycle.
REQ-010 cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-011 bte  in  2  burst type; only 00 (linear) is supported.
REQ-012 ack / err / rty  out  1 each  acknowledge, error and retry.

Function
REQ-013 A request is stb=1 and cyc=1; a request SHALL be accepted on a rising edge only when the FSM is in IDLE or BURST.
REQ-014 The FSM SHALL have three states:
- IDLE: no acknowledge pending.
- SINGLE: one classic acknowledge pending.
- BURST: streaming acknowledges.
REQ-015 On acceptance in IDLE, the FSM SHALL go to BURST if BURST_EN=1, cti=010 and bte=00; otherwise it SHALL go to SINGLE.
REQ-016 The internal ack_r flag SHALL be set on the accepting edge, so ack is high in the next cycle (latency 1).
REQ-017 The ack output SHALL equal ack_r AND stb AND cyc; this keeps ack low during master wait states.
REQ-018 SINGLE SHALL return to IDLE on the next edge and clear ack_r, so back-to-back classic cycles are acknowledged every other cycle.
REQ-019 BURST SHALL hold ack_r high and advance the internal word index by 1 on each edge where ack=1, giving one ack per cycle.
REQ-020 BURST SHALL go to IDLE on the edge where ack=1 and cti=111, or on any edge where cyc=0.
REQ-021 In BURST with stb=0 and cyc=1, the index and state SHALL hold.
REQ-022 The word index SHALL wrap modulo DEPTH_WORDS when incremented in BURST; the master's adr is ignored after the first beat.
REQ-023 Reads: dat_sm SHALL hold mem[index] in every cycle where ack=1 (synchronous read, prefetched one beat ahead in BURST), and SHALL be 0 when ack=0.
REQ-024 Writes: on each edge where ack=1 and we=1, each byte i with sel[i]=1 SHALL be written; bytes with sel[i]=0 SHALL be unchanged.
REQ-025 A read in the cycle after a write to the same word SHALL return the new data (write-first).
REQ-026 Out of range (adr[31:AW+2] != 0 at acceptance): the block SHALL assert err instead of ack with the same timing, SHALL NOT write memory, and SHALL return dat_sm=0.
REQ-027 An out-of-range request SHALL always use SINGLE.
REQ-028 err and ack SHALL never be high together.
REQ-029 rty SHALL be constant 0.
REQ-030 cyc falling to 0 in any state SHALL return the FSM to IDLE and clear ack_r on that edge.

Reset
REQ-031 On an edge with sys_rst_n=0, the block SHALL set: state IDLE, ack_r=0, err=0, word index 0, dat_sm=0.
REQ-032 Memory contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-033 A reset during a burst SHALL abort it: ack=0 from the next cycle, with no write on the reset edge.
REQ-034 The first request SHALL be accepted on the first edge with sys_rst_n=1.

Verification
REQ-035 Classic write adr=0x10, dat_ms=0xDEADBEEF, sel=1111, then classic read of 0x10 -> ack exactly one cycle after each accept; read returns 0xDEADBEEF.
REQ-036 Write 0x11223344 to 0x20 with sel=0101, word previously 0xAABBCCDD -> subsequent read returns 0xAA22CC44.
REQ-037 Burst write of 8 words at 0x100 (cti=010 for 7 beats, 111 on the last), data 0..7 -> 8 consecutive acks, then a burst read returns 0..7 and the FSM is in IDLE after the last beat.
REQ-038 Read burst with stb=0 for 2 cycles mid-burst -> ack low in those cycles, no beat skipped or repeated, data remains sequential.
REQ-039 Access at adr = DEPTH_WORDS*4 -> err high for one cycle, ack low, target word unchanged.
REQ-040 Burst starting at the last word (DEPTH_WORDS-1) for 2 beats -> second beat accesses word 0.
REQ-041 sys_rst_n driven low mid-burst -> ack=0 next cycle, state IDLE, and previously written words are still readable after reset.

Source files
------------

// File: rtl/wshb_sram_slave.sv
// wshb_sram_slave
//   Wishbone B4 slave fronting an internal word-addressed SRAM. Supports
//   classic cycles and linear incrementing bursts. Each access is acknowledged
//   one cycle after it is accepted. A burst streams one beat per cycle.
//   Any address above the memory range is answered with err.
//
// Ports
//   sys_clk      single clock, rising edge
//   sys_rst_n    synchronous active-low reset
//   adr          byte address; word index = adr[AW+1:2]
//   dat_ms       write data from master
//   dat_sm       read data to master (0 whenever ack is low)
//   sel          byte enables
//   we/stb/cyc   write enable, strobe, bus cycle
//   cti/bte      cycle type / burst type (only linear bursts supported)
//   ack/err/rty  acknowledge, error, retry (rty tied low)
//
// state  | meaning
// -------+-------------------------------------------
// IDLE   | no acknowledge pending, may accept
// SINGLE | one classic ack (or err) pending
// BURST  | streaming acks, index advances per ack
module wshb_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter bit BURST_EN    = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    output logic [31:0] dat_sm,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic        stb,
    input  logic        cyc,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ack_r_q, ack_r_d;
    logic           err_r_q, err_r_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    rd_q, rd_d;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           req;
    logic           oor;
    logic           burst_req;
    logic           wr_en;
    logic [AW-1:0]  adr_idx;
    logic [AW-1:0]  idx_inc;
    logic           unused_adr_lsb;

    assign unused_adr_lsb = ^adr[1:0];

    assign req       = stb & cyc;
    assign adr_idx   = adr[AW+1:2];
    assign oor       = |adr[31:AW+2];
    assign burst_req = BURST_EN && (cti == 3'b010) && (bte == 2'b00);
    assign idx_inc   = idx_q + 1'b1;

    // Qualifying with stb/cyc keeps ack/err low during master wait states.
    assign ack    = ack_r_q & req;
    assign err    = err_r_q & req;
    assign rty    = 1'b0;
    assign dat_sm = ack ? rd_q : 32'd0;
    assign wr_en  = ack & we;

    always_comb begin
        state_d = state_q;
        ack_r_d = ack_r_q;
        err_r_d = err_r_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d = adr_idx;
                    if (oor) begin
                        rd_d    = 32'd0;
                        err_r_d = 1'b1;
                        ack_r_d = 1'b0;
                        state_d = ST_SINGLE;
                    end else begin
                        rd_d    = mem[adr_idx];
                        ack_r_d = 1'b1;
                        err_r_d = 1'b0;
                        state_d = burst_req ? ST_BURST : ST_SINGLE;
                    end
                end
            end
            ST_SINGLE: begin
                state_d = ST_IDLE;
                ack_r_d = 1'b0;
                err_r_d = 1'b0;
            end
            ST_BURST: begin
                // Prefetch the next word while the current beat is written.
                // The write targets idx_q and the read idx_q+1, so they never
                // collide and no write-first bypass is needed here.
                if (ack) begin
                    idx_d = idx_inc;
                    rd_d  = mem[idx_inc];
                    if (cti == 3'b111) begin
                        state_d = ST_IDLE;
                        ack_r_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_r_d = 1'b0;
                err_r_d = 1'b0;
            end
        endcase
        if (!cyc) begin
            state_d = ST_IDLE;
            ack_r_d = 1'b0;
            err_r_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            ack_r_q <= 1'b0;
            err_r_q <= 1'b0;
            idx_q   <= '0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ack_r_q <= ack_r_d;
            err_r_q <= err_r_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
        end
    end

    // Memory is never cleared; reset only suppresses a write on its edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    mem[idx_q][8*i +: 8] <= dat_ms[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wshb_sram_slave.sv
// tb_wshb_sram_slave
//   Directed bench for wshb_sram_slave (DEPTH_WORDS=1024, BURST_EN=1).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
module tb_wshb_sram_slave;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    int n_cmp = 0;
    int n_err = 0;

    wshb_sram_slave #(
        .DEPTH_WORDS (1024),
        .BURST_EN    (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .adr       (adr),
        .dat_ms    (dat_ms),
        .dat_sm    (dat_sm),
        .sel       (sel),
        .we        (we),
        .stb       (stb),
        .cyc       (cyc),
        .cti       (cti),
        .bte       (bte),
        .ack       (ack),
        .err       (err),
        .rty       (rty)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        sel    = 4'h0;
        cti    = 3'b000;
        bte    = 2'b00;
        adr    = 32'd0;
        dat_ms = 32'd0;
    endtask

    // Classic cycle: accept cycle, ack/err cycle, then a gap cycle with the
    // request still held (nothing may be acknowledged there), then abort.
    task automatic classic(input string tag, input logic [31:0] a, input bit w,
                           input logic [31:0] d, input logic [3:0] s,
                           input bit exp_err, input bit chk_rd, input logic [31:0] exp_rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s;
        cti = 3'b000; bte = 2'b00;
        @(negedge sys_clk);
        chk({tag, "_acc"}, 32'(ack), 32'd0);
        tick();
        @(negedge sys_clk);
        chk({tag, "_ack"}, 32'(ack), 32'(!exp_err));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        if (chk_rd) chk({tag, "_dat"}, dat_sm, exp_rd);
        tick();
        @(negedge sys_clk);
        chk({tag, "_gap"}, 32'(ack | err), 32'd0);
        tick();
        bus_idle();
        tick();
    endtask

    task automatic burst_wr(input string tag, input logic [31:0] a, input int n,
                            input logic [31:0] base);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = a;
        cti = 3'b010; bte = 2'b00; dat_ms = base;
        @(negedge sys_clk);
        chk({tag, "_acc"}, 32'(ack), 32'd0);
        tick();
        adr = 32'hFFFF_FFFC;
        for (int k = 0; k < n; k++) begin
            dat_ms = base + 32'(k);
            cti    = (k == n - 1) ? 3'b111 : 3'b010;
            @(negedge sys_clk);
            chk({tag, "_beat"}, 32'(ack), 32'd1);
            tick();
        end
        we = 1'b0; cti = 3'b000;
        @(negedge sys_clk);
        chk({tag, "_end"}, 32'(ack), 32'd0);
        tick();
        bus_idle();
        tick();
    endtask

    // Burst read expecting base+k on beat k; two wait-state cycles are
    // inserted before beat stall_at (use -1 for none).
    task automatic burst_rd(input string tag, input logic [31:0] a, input int n,
                            input logic [31:0] base, input int stall_at);
        int k;
        int st;
        k = 0;
        st = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
        cti = 3'b010; bte = 2'b00;
        @(negedge sys_clk);
        chk({tag, "_acc"}, 32'(ack), 32'd0);
        tick();
        adr = 32'hFFFF_FFFC;
        for (int c = 0; c < n + 4 && k < n; c++) begin
            if (k == stall_at && st < 2) begin
                stb = 1'b0;
                @(negedge sys_clk);
                chk({tag, "_stall"}, 32'(ack), 32'd0);
                st++;
            end else begin
                stb = 1'b1;
                cti = (k == n - 1) ? 3'b111 : 3'b010;
                @(negedge sys_clk);
                chk({tag, "_ack"}, 32'(ack), 32'd1);
                chk({tag, "_dat"}, dat_sm, base + 32'(k));
                k++;
            end
            tick();
        end
        chk({tag, "_beats"}, 32'(k), 32'(n));
        stb = 1'b1; cti = 3'b000;
        @(negedge sys_clk);
        chk({tag, "_end"}, 32'(ack), 32'd0);
        tick();
        bus_idle();
        tick();
    endtask

    initial begin
        bus_idle();
        sys_rst_n = 1'b0;
        cyc = 1'b1; stb = 1'b1; adr = 32'h10;
        repeat (3) tick();
        @(negedge sys_clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", dat_sm, 32'd0);
        chk("rst_rty", 32'(rty), 32'd0);
        tick();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rel_acc", 32'(ack), 32'd0);
        tick();
        @(negedge sys_clk);
        chk("rel_first_ack", 32'(ack), 32'd1);
        tick();
        bus_idle();
        tick();

        classic("wr10", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'd0);
        classic("rd10", 32'h10, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);

        classic("wr20a", 32'h20, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'd0);
        classic("wr20b", 32'h20, 1'b1, 32'h11223344, 4'b0101, 1'b0, 1'b0, 32'd0);
        classic("rd20", 32'h20, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hAA22CC44);

        burst_wr("bw100", 32'h100, 8, 32'd0);
        burst_rd("br100", 32'h100, 8, 32'd0, -1);
        burst_rd("brstl", 32'h100, 8, 32'd0, 3);

        // 0x1000 aliases word 0 if the range check were missing.
        classic("wr0", 32'h0, 1'b1, 32'h01234567, 4'hF, 1'b0, 1'b0, 32'd0);
        classic("oor_wr", 32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'd0);
        classic("oor_rd", 32'h1000, 1'b0, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);
        classic("rd0", 32'h0, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'h01234567);

        burst_wr("bwwrap", 32'hFFC, 2, 32'hC0DE0000);
        classic("rdw0", 32'h0, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hC0DE0001);
        classic("rdwlast", 32'hFFC, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hC0DE0000);
        burst_rd("brwrap", 32'hFFC, 2, 32'hC0DE0000, -1);

        // Reset in the middle of a read burst; the beat in flight carries a
        // write that must be dropped by the reset edge.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h100;
        cti = 3'b010; bte = 2'b00;
        @(negedge sys_clk);
        chk("rb_acc", 32'(ack), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk("rb_dat", dat_sm, 32'(k));
            tick();
        end
        we = 1'b1; dat_ms = 32'hBAD0BAD0;
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        we = 1'b0; cti = 3'b000; adr = 32'h10C;
        @(negedge sys_clk);
        chk("rb_post_ack", 32'(ack), 32'd0);
        tick();
        @(negedge sys_clk);
        chk("rb_rel_ack", 32'(ack), 32'd1);
        chk("rb_nowrite", dat_sm, 32'd3);
        tick();
        bus_idle();
        tick();
        classic("rd10post", 32'h10, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
        classic("rd104post", 32'h104, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
